// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder family: state encodings and a
// reference one-hot helper sized for the widest supported select.
package decoder_pkg;

   localparam logic ST_DIRECT = 1'b0;
   localparam logic ST_SCAN   = 1'b1;

   // Widest select any decoder variant may use; narrower users truncate.
   localparam int MAX_N = 8;

   function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] sel);
      logic [2**MAX_N-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder_nx.sv
// Combinational N -> 2**N one-hot decoder, N must not exceed MAX_N.
module decoder_nx
   import decoder_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]    sel,
   output logic [2**N-1:0] dec
);

   localparam int W = 2**N;

   assign dec = W'(onehot(MAX_N'(sel)));

endmodule

// File: rtl/decoder_scan_nx.sv
// Registered one-hot decoder: DIRECT decodes handshaked selects, SCAN strobes
// every output in turn with a programmable dwell per step.
module decoder_scan_nx
   import decoder_pkg::*;
#(
   parameter int N       = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2**N-1:0]    out,
   output logic [N-1:0]       out_idx,
   output logic               wrap,
   output logic               dbg_state
);

   // Handshake: a select transfers on a rising clk edge when in_valid and
   // in_ready are both high; in_ready never depends on in_valid.
   logic               state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]       idx_d;
   logic               live_q, live_d;
   logic               blank_d;
   logic               wrap_d;
   logic               xfer;
   logic [2**N-1:0]    dec;

   assign in_ready  = en & ~mode & ~rst;
   assign xfer      = in_valid & in_ready;
   assign dbg_state = state_q;

   decoder_nx #(.N(N)) u_dec (
      .sel (idx_d),
      .dec (dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_DIRECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = mode ? ST_SCAN : ST_DIRECT;
   end

   // live_q remembers that DIRECT holds a decoded value worth restoring
   // after a blanking period; a blank SCAN output means the step must load.
   always_comb begin
      idx_d   = out_idx;
      cnt_d   = cnt_q;
      live_d  = live_q;
      blank_d = 1'b1;
      wrap_d  = 1'b0;
      if (xfer) begin
         idx_d   = in_sel;
         cnt_d   = '0;
         live_d  = 1'b1;
         blank_d = 1'b0;
      end else if (mode != state_q) begin
         idx_d  = '0;
         cnt_d  = '0;
         live_d = 1'b0;
      end else if (!en) begin
         blank_d = 1'b1;
      end else if (state_q == ST_DIRECT) begin
         blank_d = ~live_q;
      end else begin
         blank_d = 1'b0;
         if (out == '0) begin
            cnt_d = cnt_q;
         end else if (cnt_q >= dwell) begin
            cnt_d  = '0;
            idx_d  = out_idx + N'(1);
            wrap_d = (out_idx == '1);
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out     <= '0;
         out_idx <= '0;
         wrap    <= 1'b0;
         cnt_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         out     <= blank_d ? '0 : dec;
         out_idx <= idx_d;
         wrap    <= wrap_d;
         cnt_q   <= cnt_d;
         live_q  <= live_d;
      end
   end

endmodule
